// File: rtl/port_wide_serializer_pkg.sv
// Shared constants, state encoding and sizing helpers for the wide-word serializer.
package port_test_pkg;

  localparam int unsigned DEF_WIDTH  = 8888;
  localparam int unsigned DEF_WORD_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  function automatic int unsigned num_words(input int unsigned width, input int unsigned word_w);
    return (width + word_w - 1) / word_w;
  endfunction

  // Index width never drops below one bit, even for a single-chunk frame.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/port_wide_serializer_if.sv
// Start/capture and chunk-stream handshake bundle of the wide-word serializer.
interface port_wide_serializer_if
  import port_test_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned WORD_W = DEF_WORD_W
);

  localparam int unsigned IDX_W = idx_w(num_words(WIDTH, WORD_W));

  logic              start;
  logic [WIDTH-1:0]  wide_in;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;
  logic [IDX_W-1:0]  out_index;
  logic              out_last;
  logic              done;

  modport master (
    input  start, wide_in, out_ready,
    output busy, out_valid, out_data, out_index, out_last, done
  );

  modport slave (
    output start, wide_in, out_ready,
    input  busy, out_valid, out_data, out_index, out_last, done
  );

endinterface

// File: rtl/port_wide_serializer.sv
// Captures a wide word on start and emits it as WORD_W chunks, LSB chunk first,
// over a valid/ready stream; pulses done once after the final chunk.
module port_wide_serializer
  import port_test_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned WORD_W = DEF_WORD_W
) (
  input logic                   clk,
  input logic                   rst_n,
  port_wide_serializer_if.master bus
);

  localparam int unsigned NUM_WORDS = num_words(WIDTH, WORD_W);
  localparam int unsigned IDX_W     = idx_w(NUM_WORDS);
  localparam int unsigned PAD_W     = NUM_WORDS * WORD_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  state_t            state;
  logic [PAD_W-1:0]  padded;
  logic [PAD_W-1:0]  shadow;
  logic [WORD_W-1:0] data_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx_next;
  logic              valid_q;
  logic              last_q;
  logic              done_q;
  logic              busy_q;
  logic              accept;
  logic              advance;

  always_comb begin
    padded              = '0;
    padded[WIDTH-1:0]   = bus.wide_in;
  end

  assign accept   = (state == IDLE) && bus.start;
  assign advance  = (state == SEND) && bus.out_ready;
  assign idx_next = idx_q + 1'b1;

  // Shadow holds the chunks still queued behind the one on out_data, so the
  // next chunk is always its low word. No reset: out_data is gated separately.
  always_ff @(posedge clk) begin
    if (accept) begin
      shadow <= padded >> WORD_W;
    end else if (advance) begin
      shadow <= shadow >> WORD_W;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= SEND;
            busy_q  <= 1'b1;
            valid_q <= 1'b1;
            idx_q   <= '0;
            data_q  <= padded[WORD_W-1:0];
            last_q  <= (NUM_WORDS == 1);
          end
        end
        SEND: begin
          if (bus.out_ready) begin
            if (last_q) begin
              state   <= IDLE;
              busy_q  <= 1'b0;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              idx_q   <= '0;
              data_q  <= '0;
              done_q  <= 1'b1;
            end else begin
              idx_q  <= idx_next;
              data_q <= shadow[WORD_W-1:0];
              last_q <= (idx_next == LAST_IDX);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_index = idx_q;
  assign bus.out_last  = last_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_port_wide_serializer.sv
// Self-checking bench: frame-level chunk model plus directed scenarios and a 64-bit instance.
module tb_port_wide_serializer;

  localparam int unsigned W  = 8888;
  localparam int unsigned WW = 32;
  localparam int unsigned N  = (W + WW - 1) / WW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  port_wide_serializer_if #(.WIDTH(W),  .WORD_W(WW)) bus ();
  port_wide_serializer_if #(.WIDTH(64), .WORD_W(32)) sbus ();

  port_wide_serializer #(.WIDTH(W), .WORD_W(WW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  port_wide_serializer #(.WIDTH(64), .WORD_W(32)) dut_small (
    .clk(clk), .rst_n(rst_n), .bus(sbus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Frame model: a captured frame is just the zero-padded word cut into 32-bit slices.
  logic [WW-1:0]   fr [N];
  logic [N*WW-1:0] mpad;
  bit              m_active = 1'b0;
  int              m_k = 0;
  bit              exp_done = 1'b0;
  bit              prev_stall = 1'b0;
  logic [WW-1:0]   prev_data;
  int              done_cnt = 0;
  int              xfer_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_active   = 1'b0;
      m_k        = 0;
      exp_done   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk("done", 64'(bus.done), 64'(exp_done));
      if (bus.done) done_cnt++;
      chk("busy", 64'(bus.busy), 64'(m_active));
      chk("out_valid", 64'(bus.out_valid), 64'(m_active));
      if (m_active) begin
        chk("out_data", 64'(bus.out_data), 64'(fr[m_k]));
        chk("out_index", 64'(bus.out_index), 64'(m_k));
        chk("out_last", 64'(bus.out_last), 64'(m_k == int'(N) - 1));
      end else begin
        chk("idle_data", 64'(bus.out_data), 64'd0);
        chk("idle_last", 64'(bus.out_last), 64'd0);
      end
      if (prev_stall) chk("stall_hold", 64'(bus.out_data), 64'(prev_data));
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      exp_done = 1'b0;
      if (m_active) begin
        if (bus.out_ready) begin
          xfer_cnt++;
          if (m_k == int'(N) - 1) begin
            m_active = 1'b0;
            exp_done = 1'b1;
          end else begin
            m_k++;
          end
        end
      end else if (bus.start) begin
        mpad = '0;
        mpad[W-1:0] = bus.wide_in;
        for (int k = 0; k < int'(N); k++) fr[k] = mpad[k*WW +: WW];
        m_active = 1'b1;
        m_k = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (cyc < budget) begin
      step();
      cyc++;
      if (bus.done) break;
    end
    chk("done_seen", 64'(bus.done), 64'd1);
  endtask

  task automatic wait_index(input int idx, input int budget);
    int c = 0;
    while (c < budget && !(bus.out_valid && int'(bus.out_index) == idx)) begin
      step();
      c++;
    end
    chk("reach_index", 64'(bus.out_index), 64'(idx));
  endtask

  logic [W-1:0] pat;
  logic [W-1:0] rnd;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int d0;
    int x0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.out_ready = 1'b0; bus.wide_in = '0;
    sbus.start = 1'b0; sbus.out_ready = 1'b0; sbus.wide_in = '0;
    for (int i = 0; i < int'(W / 8); i++) pat[8*i +: 8] = 8'(i);
    for (int i = 0; i < int'(W); i++) rnd[i] = 1'($urandom);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("rst_busy",  64'(bus.busy), 64'd0);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_data",  64'(bus.out_data), 64'd0);
    chk("rst_index", 64'(bus.out_index), 64'd0);
    chk("rst_done",  64'(bus.done), 64'd0);

    // Full-rate frame; wide_in is scrambled right after capture.
    bus.wide_in = pat; bus.out_ready = 1'b1; bus.start = 1'b1;
    x0 = xfer_cnt;
    step();
    bus.start = 1'b0; bus.wide_in = rnd;
    chk("model_chunk0",   64'(fr[0]), 64'h03020100);
    chk("model_chunk277", 64'(fr[N-1]), 64'h00565554);
    chk("first_chunk",    64'(bus.out_data), 64'h03020100);
    cyc = 0;
    while (cyc < 400 && !bus.out_last) begin step(); cyc++; end
    chk("last_after_cycles", 64'(cyc), 64'd277);
    chk("last_index", 64'(bus.out_index), 64'd277);
    chk("last_chunk", 64'(bus.out_data), 64'h00565554);
    step();
    chk("done_after_last", 64'(bus.done), 64'd1);
    chk("xfers_frame1", 64'(xfer_cnt - x0), 64'd278);
    step();
    chk("done_one_cycle", 64'(bus.done), 64'd0);

    // Random backpressure.
    bus.wide_in = rnd; bus.start = 1'b1; bus.out_ready = 1'($urandom_range(0, 1));
    step();
    bus.start = 1'b0;
    cyc = 0;
    while (cyc < 3000 && !bus.done) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      step();
      cyc++;
    end
    chk("done_backpressure", 64'(bus.done), 64'd1);
    bus.out_ready = 1'b1;
    step();

    // Start mid-frame must be ignored.
    bus.wide_in = pat; bus.start = 1'b1;
    d0 = done_cnt;
    step();
    bus.start = 1'b0;
    wait_index(100, 300);
    bus.wide_in = rnd; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_done(400, cyc);
    repeat (5) step();
    chk("single_done", 64'(done_cnt - d0), 64'd1);

    // Reset mid-frame.
    bus.wide_in = pat; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_index(50, 200);
    d0 = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy",  64'(bus.busy), 64'd0);
    chk("arst_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_last",  64'(bus.out_last), 64'd0);
    chk("arst_done",  64'(bus.done), 64'd0);
    chk("arst_index", 64'(bus.out_index), 64'd0);
    chk("arst_data",  64'(bus.out_data), 64'd0);
    step();
    rst_n = 1'b1;
    repeat (5) step();
    chk("no_done_after_rst", 64'(done_cnt - d0), 64'd0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("restart_index", 64'(bus.out_index), 64'd0);
    chk("restart_valid", 64'(bus.out_valid), 64'd1);
    wait_done(400, cyc);
    chk("restart_len", 64'(cyc), 64'd278);
    step();

    // Start held high: done cycle doubles as the next accepted start.
    bus.start = 1'b1;
    step();
    wait_done(400, cyc);
    step();
    chk("b2b_busy",  64'(bus.busy), 64'd1);
    chk("b2b_index", 64'(bus.out_index), 64'd0);
    wait_done(400, cyc);
    chk("b2b_len", 64'(cyc), 64'd278);
    bus.start = 1'b0;
    step();
    chk("b2b_idle", 64'(bus.busy), 64'd0);

    // Two-chunk instance.
    sbus.wide_in = 64'hDEADBEEF_01234567; sbus.out_ready = 1'b0; sbus.start = 1'b1;
    step();
    sbus.start = 1'b0;
    chk("s_valid0", 64'(sbus.out_valid), 64'd1);
    chk("s_data0",  64'(sbus.out_data), 64'h01234567);
    chk("s_index0", 64'(sbus.out_index), 64'd0);
    chk("s_last0",  64'(sbus.out_last), 64'd0);
    step();
    chk("s_stall",  64'(sbus.out_data), 64'h01234567);
    sbus.out_ready = 1'b1;
    step();
    chk("s_data1",  64'(sbus.out_data), 64'hDEADBEEF);
    chk("s_index1", 64'(sbus.out_index), 64'd1);
    chk("s_last1",  64'(sbus.out_last), 64'd1);
    step();
    chk("s_done",   64'(sbus.done), 64'd1);
    chk("s_idle_valid", 64'(sbus.out_valid), 64'd0);
    chk("s_idle_data",  64'(sbus.out_data), 64'd0);
    step();
    chk("s_done_clear", 64'(sbus.done), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/port_wide_serializer.md
PORT_WIDE_SERIALIZER -- requirements
Module: port_wide_serializer

Interface
REQ-001 Parameter WIDTH, default 8888, SHALL set the bit width of the wide input word.
REQ-002 Parameter WORD_W, default 32, SHALL set the bit width of each output chunk.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 start  input  1  SHALL request capture and serialization of wide_in; sampled only in IDLE.
REQ-006 wide_in  input  WIDTH  SHALL be the wide value to serialize; sampled on the accepted-start edge.
REQ-007 busy  output  1  SHALL be high while the state is not IDLE.
REQ-008 out_valid  output  1  SHALL indicate out_data, out_last and out_index hold a valid chunk.
REQ-009 out_ready  input  1  SHALL be the consumer's acceptance; a transfer occurs on a clock edge with out_valid and out_ready both high.
REQ-010 out_data  output  WORD_W  SHALL be the current chunk, least-significant chunk first.
REQ-011 out_index  output  IDX_W  SHALL be the zero-based chunk number, IDX_W = clog2(NUM_WORDS), minimum 1.
REQ-012 out_last  output  1  SHALL be high with the final chunk (out_index == NUM_WORDS-1).
REQ-013 done  output  1  SHALL pulse high for exactly one cycle after the final transfer.

Function
REQ-014 NUM_WORDS SHALL equal ceil(WIDTH/WORD_W); for the defaults it SHALL be 278.
REQ-015 Bits of the final chunk above WIDTH SHALL be zero (defaults: chunk 277 bits [31:24] = 0).
REQ-016 States SHALL be IDLE and SEND.
REQ-017 IDLE with start=1 SHALL capture wide_in into a zero-padded shadow register, clear out_index, and enter SEND on the same edge.
REQ-018 out_valid SHALL be high in every SEND cycle, so the first chunk is valid one cycle after start.
REQ-019 Each transfer that is not the last SHALL advance to the next chunk and increment out_index by 1.
REQ-020 While out_valid=1 and out_ready=0, out_data, out_index and out_last SHALL hold stable.
REQ-021 A transfer with out_last=1 SHALL return the state to IDLE and assert done in the following cycle.
REQ-022 start in SEND SHALL be ignored; wide_in changes after capture SHALL NOT affect output.
REQ-023 start in the cycle done is high SHALL be accepted, giving back-to-back frames with no dead cycle beyond done.
REQ-024 With NUM_WORDS=1, the first chunk SHALL carry out_last=1.
REQ-025 out_ready in IDLE SHALL have no effect.

Reset
REQ-026 Asserting rst_n low SHALL immediately force IDLE, busy=0, out_valid=0, out_last=0, done=0, out_index=0 and out_data=0, including mid-frame.
REQ-027 A frame interrupted by reset SHALL be discarded; no done pulse SHALL follow.
REQ-028 The shadow register MAY be left non-reset, but out_data SHALL read 0 whenever out_valid=0.

Structure
REQ-029 Package port_test_pkg SHALL hold default WIDTH/WORD_W constants, the state enum, and a num_words(width, word_w) function.
REQ-030 Chunk selection SHALL use a right-shift of the shadow register by WORD_W per transfer, not a NUM_WORDS-way mux.
REQ-031 No sub-module is required; the block SHALL be a single module.

Verification
REQ-032 Defaults, wide_in = incrementing byte pattern, out_ready=1 -> 278 transfers in 278 consecutive cycles, chunk k = wide_in[32k+31:32k], out_last only at index 277 with bits [31:24]=0, done one cycle later.
REQ-033 out_ready toggled pseudo-randomly (50%) -> identical chunk sequence; chunk held stable on every stalled cycle.
REQ-034 start pulsed at chunk 100 with different wide_in -> ignored; original frame completes unchanged, single done.
REQ-035 rst_n low at chunk 50 -> all outputs 0 asynchronously; no done; new start then produces a full 278-chunk frame from index 0.
REQ-036 WIDTH=64, WORD_W=32, wide_in=64'hDEADBEEF_01234567 -> chunk 0 = 32'h01234567, chunk 1 = 32'hDEADBEEF with out_last, no padding.
REQ-037 start held high continuously, out_ready=1 -> consecutive frames; each done cycle coincides with the next accepted start.
